// File: rtl/l2_cache_write.sv
// l2_cache_write: write side of the L2 data SRAM. Merges store bytes or installs fill lines,
// issues one registered SRAM write per qualifying transaction and forwards its last write.
module l2_cache_write #(
  parameter int SET_BITS  = 6,
  parameter int WAY_BITS  = 2,
  parameter int LINE_BITS = 512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall_pipeline,
  input  logic                          rd_pci_valid,
  input  logic [2:0]                    rd_pci_op,
  input  logic [1:0]                    rd_pci_strand,
  input  logic [25:0]                   rd_pci_address,
  input  logic [LINE_BITS-1:0]          rd_pci_data,
  input  logic [LINE_BITS/8-1:0]        rd_pci_mask,
  input  logic                          rd_cache_hit,
  input  logic [WAY_BITS-1:0]           rd_hit_l2_way,
  input  logic                          rd_has_sm_data,
  input  logic [LINE_BITS-1:0]          rd_sm_data,
  input  logic [WAY_BITS-1:0]           rd_sm_fill_l2_way,
  input  logic [LINE_BITS-1:0]          rd_cache_mem_result,
  input  logic                          rd_store_sync_success,
  output logic                          wr_update_l2_data,
  output logic [WAY_BITS+SET_BITS-1:0]  wr_cache_write_index,
  output logic [LINE_BITS-1:0]          wr_update_data,
  output logic                          wr_pci_valid,
  output logic [2:0]                    wr_pci_op,
  output logic [1:0]                    wr_pci_strand,
  output logic [25:0]                   wr_pci_address,
  output logic [LINE_BITS-1:0]          wr_data,
  output logic                          wr_store_sync_success
);

  localparam int IDX_BITS  = WAY_BITS + SET_BITS;
  localparam int MASK_BITS = LINE_BITS / 8;

  localparam logic [2:0] OP_STORE      = 3'd1;
  localparam logic [2:0] OP_STORE_SYNC = 3'd5;

  logic                 r_update_l2_data;
  logic [IDX_BITS-1:0]  r_write_index;
  logic [LINE_BITS-1:0] r_update_data;
  logic                 r_pci_valid;
  logic [2:0]           r_pci_op;
  logic [1:0]           r_pci_strand;
  logic [25:0]          r_pci_address;
  logic [LINE_BITS-1:0] r_data;
  logic                 r_store_sync_success;

  logic [IDX_BITS-1:0]  w_idx;
  logic                 w_bypass;
  logic [LINE_BITS-1:0] w_base;
  logic [LINE_BITS-1:0] w_merged;
  logic                 w_do_store;
  logic                 w_do_write;

  // Only a write issued on the previous edge is forwarded; a held (stalled) line is not live.
  always_comb begin
    w_idx      = {rd_cache_hit ? rd_hit_l2_way : rd_sm_fill_l2_way, rd_pci_address[SET_BITS-1:0]};
    w_bypass   = r_update_l2_data && (r_write_index == w_idx);
    w_do_store = rd_pci_valid && (rd_cache_hit || rd_has_sm_data) &&
                 ((rd_pci_op == OP_STORE) || ((rd_pci_op == OP_STORE_SYNC) && rd_store_sync_success));
    w_do_write = w_do_store || (rd_pci_valid && rd_has_sm_data);
    if (rd_has_sm_data)
      w_base = rd_sm_data;
    else if (w_bypass)
      w_base = r_update_data;
    else
      w_base = rd_cache_mem_result;
    w_merged = w_base;
    for (int i = 0; i < MASK_BITS; i++) begin
      if (w_do_store && rd_pci_mask[i])
        w_merged[i*8 +: 8] = rd_pci_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_update_l2_data     <= 1'b0;
      r_write_index        <= '0;
      r_update_data        <= '0;
      r_pci_valid          <= 1'b0;
      r_pci_op             <= '0;
      r_pci_strand         <= '0;
      r_pci_address        <= '0;
      r_data               <= '0;
      r_store_sync_success <= 1'b0;
    end else if (stall_pipeline) begin
      r_update_l2_data     <= 1'b0;
    end else begin
      r_update_l2_data     <= w_do_write;
      r_write_index        <= w_idx;
      r_update_data        <= w_merged;
      r_pci_valid          <= rd_pci_valid;
      r_pci_op             <= rd_pci_op;
      r_pci_strand         <= rd_pci_strand;
      r_pci_address        <= rd_pci_address;
      r_data               <= w_merged;
      r_store_sync_success <= rd_store_sync_success;
    end
  end

  assign wr_update_l2_data     = r_update_l2_data;
  assign wr_cache_write_index  = r_write_index;
  assign wr_update_data        = r_update_data;
  assign wr_pci_valid          = r_pci_valid;
  assign wr_pci_op             = r_pci_op;
  assign wr_pci_strand         = r_pci_strand;
  assign wr_pci_address        = r_pci_address;
  assign wr_data               = r_data;
  assign wr_store_sync_success = r_store_sync_success;

endmodule
